// File: rtl/q_operand_fetch.sv
// q_operand_fetch: read side of the Q-learning update loop.
// For one transition (s, a, r, s') it reads Q(s,a), scans Q(s',0..N-1) for the
// float maximum, and presents {q, max_q, rt} with a one-cycle valid pulse.
// It then waits for the updated Q and writes it back to Q(s,a).
// Every output is a flop; the next value of each output is computed in the
// same combinational block that computes the next FSM state.
module q_operand_fetch #(
    parameter int DATA_WIDTH   = 32,
    parameter int STATE_WIDTH  = 4,
    parameter int ACTION_WIDTH = 2,
    parameter int NUM_ACTIONS  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic [STATE_WIDTH-1:0]              i_state,
    input  logic [ACTION_WIDTH-1:0]             i_action,
    input  logic [STATE_WIDTH-1:0]              i_next_state,
    input  logic [DATA_WIDTH-1:0]               i_reward,
    output logic                                o_busy,
    output logic                                o_rd_en,
    output logic [STATE_WIDTH+ACTION_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]               i_rd_data,
    output logic [DATA_WIDTH-1:0]               o_q,
    output logic [DATA_WIDTH-1:0]               o_max_q,
    output logic [DATA_WIDTH-1:0]               o_rt,
    output logic                                o_valid,
    input  logic [DATA_WIDTH-1:0]               i_q_new,
    input  logic                                i_q_new_valid,
    output logic                                o_wr_en,
    output logic [STATE_WIDTH+ACTION_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]               o_wr_data,
    output logic                                o_done
);

    localparam int AW = STATE_WIDTH + ACTION_WIDTH;
    localparam logic [ACTION_WIDTH-1:0] LAST_IDX = ACTION_WIDTH'(NUM_ACTIONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SCAN,
        S_DRAIN,
        S_EMIT,
        S_WAIT_WB,
        S_DONE
    } state_t;

    // Operands latched at accept; held stable for the whole transaction.
    typedef struct packed {
        logic [STATE_WIDTH-1:0]  s;
        logic [ACTION_WIDTH-1:0] a;
        logic [STATE_WIDTH-1:0]  sn;
        logic [DATA_WIDTH-1:0]   r;
    } req_t;

    state_t                  state_q, state_d;
    req_t                    req_q, req_d;
    logic [ACTION_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   q_acc_q, q_acc_d;
    logic [DATA_WIDTH-1:0]   max_acc_q, max_acc_d;
    logic                    max_vld_q, max_vld_d;
    logic [DATA_WIDTH-1:0]   fold;

    logic                    busy_q, busy_d;
    logic                    rd_en_q, rd_en_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   q_out_q, q_out_d;
    logic [DATA_WIDTH-1:0]   max_out_q, max_out_d;
    logic [DATA_WIDTH-1:0]   rt_q, rt_d;
    logic                    valid_q, valid_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    done_q, done_d;

    // True when cand is strictly greater than inc. Zero of either sign is
    // treated as non-negative so +0 and -0 compare equal; ties keep inc.
    function automatic logic fgt(input logic [DATA_WIDTH-1:0] inc,
                                 input logic [DATA_WIDTH-1:0] cand);
        logic inc_neg;
        logic cand_neg;
        inc_neg  = inc[DATA_WIDTH-1]  && (inc[DATA_WIDTH-2:0]  != '0);
        cand_neg = cand[DATA_WIDTH-1] && (cand[DATA_WIDTH-2:0] != '0);
        if (inc_neg != cand_neg)
            return inc_neg;
        else if (!inc_neg)
            return cand[DATA_WIDTH-2:0] > inc[DATA_WIDTH-2:0];
        else
            return cand[DATA_WIDTH-2:0] < inc[DATA_WIDTH-2:0];
    endfunction

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        idx_d     = idx_q;
        q_acc_d   = q_acc_q;
        max_acc_d = max_acc_q;
        max_vld_d = max_vld_q;
        busy_d    = busy_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        q_out_d   = q_out_q;
        max_out_d = max_out_q;
        rt_d      = rt_q;
        valid_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        // First returned scan word seeds the max; later words only replace it
        // when strictly greater.
        fold = (max_vld_q && !fgt(max_acc_q, i_rd_data)) ? max_acc_q : i_rd_data;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    req_d.s   = i_state;
                    req_d.a   = i_action;
                    req_d.sn  = i_next_state;
                    req_d.r   = i_reward;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {i_state, i_action};
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                // Q(s,a) read is on the bus; queue the first scan read.
                rd_en_d   = 1'b1;
                rd_addr_d = {req_q.sn, {ACTION_WIDTH{1'b0}}};
                idx_d     = '0;
                max_vld_d = 1'b0;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                // Data returning now belongs to the read issued last cycle:
                // Q(s,a) on the first scan cycle, then Q(s',idx-1).
                if (idx_q == '0) begin
                    q_acc_d = i_rd_data;
                end else begin
                    max_acc_d = fold;
                    max_vld_d = 1'b1;
                end
                if (idx_q != LAST_IDX) begin
                    idx_d     = idx_q + ACTION_WIDTH'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = {req_q.sn, idx_q + ACTION_WIDTH'(1)};
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last scan word arrives; result goes straight to the outputs.
                max_acc_d = fold;
                max_vld_d = 1'b1;
                max_out_d = fold;
                q_out_d   = q_acc_q;
                rt_d      = req_q.r;
                valid_d   = 1'b1;
                state_d   = S_EMIT;
            end
            S_EMIT: begin
                // Updater cannot answer before it has seen o_valid.
                state_d = S_WAIT_WB;
            end
            S_WAIT_WB: begin
                if (i_q_new_valid) begin
                    wr_en_d   = 1'b1;
                    done_d    = 1'b1;
                    wr_addr_d = {req_q.s, req_q.a};
                    wr_data_d = i_q_new;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // Write pulse is on the bus this cycle; drop busy next.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction with no write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            idx_q     <= '0;
            q_acc_q   <= '0;
            max_acc_q <= '0;
            max_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            q_out_q   <= '0;
            max_out_q <= '0;
            rt_q      <= '0;
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            q_acc_q   <= q_acc_d;
            max_acc_q <= max_acc_d;
            max_vld_q <= max_vld_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            q_out_q   <= q_out_d;
            max_out_q <= max_out_d;
            rt_q      <= rt_d;
            valid_q   <= valid_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = rd_addr_q;
    assign o_q       = q_out_q;
    assign o_max_q   = max_out_q;
    assign o_rt      = rt_q;
    assign o_valid   = valid_q;
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_done    = done_q;

endmodule
